// File: rtl/fetch_queue_if.sv
// IF/ID side signals of the fetch queue. The DUT uses the slave modport;
// the fetch/decode side uses the master modport.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      PC_IF;
  logic [31:0]      INSTRUCTION_IF;
  logic             flush;
  logic             ID_ready;
  logic             PC_write;
  logic [31:0]      PC_ID;
  logic [31:0]      INSTRUCTION_ID;
  logic             valid_ID;
  logic [CNT_W-1:0] count;

  modport master (
    output PC_IF, INSTRUCTION_IF, flush, ID_ready,
    input  PC_write, PC_ID, INSTRUCTION_ID, valid_ID, count
  );

  modport slave (
    input  PC_IF, INSTRUCTION_IF, flush, ID_ready,
    output PC_write, PC_ID, INSTRUCTION_ID, valid_ID, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO decoupling IF from ID. Every output comes from a flop; the head
// entry is selected one cycle early so decode sees it straight from a register.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  fq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             push, pop;

  logic [31:0]      head_pc, head_instr, head_pc_nxt, head_instr_nxt;
  logic             head_vld, pc_write_q;

  // Pointer/occupancy update; flush beats push and pop.
  always_comb begin
    push           = pc_write_q & ~fq.flush & ~reset;
    pop            = fq.ID_ready & head_vld & ~fq.flush & ~reset;
    rd_nxt         = rd_ptr;
    wr_nxt         = wr_ptr;
    cnt_nxt        = cnt;
    head_pc_nxt    = 32'h0;
    head_instr_nxt = NOP;
    if (fq.flush) begin
      rd_nxt  = wr_ptr;
      cnt_nxt = CNT_W'(0);
    end else begin
      if (push) wr_nxt = wr_ptr + PTR_W'(1);
      if (pop)  rd_nxt = rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt_nxt = cnt + CNT_W'(1);
      else if (pop && !push) cnt_nxt = cnt - CNT_W'(1);
    end
    // Next head is the entry being written this edge when it lands in the read slot.
    if (cnt_nxt != CNT_W'(0)) begin
      if (push && (rd_nxt == wr_ptr)) begin
        head_pc_nxt    = fq.PC_IF;
        head_instr_nxt = fq.INSTRUCTION_IF;
      end else begin
        head_pc_nxt    = mem[rd_nxt].pc;
        head_instr_nxt = mem[rd_nxt].instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      head_pc    <= 32'h0;
      head_instr <= NOP;
      head_vld   <= 1'b0;
      pc_write_q <= 1'b1;
    end else begin
      rd_ptr     <= rd_nxt;
      wr_ptr     <= wr_nxt;
      cnt        <= cnt_nxt;
      head_pc    <= head_pc_nxt;
      head_instr <= head_instr_nxt;
      head_vld   <= (cnt_nxt != CNT_W'(0));
      pc_write_q <= (cnt_nxt != CNT_W'(DEPTH));
    end
  end

  // Storage is not reset; outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: fq.PC_IF, instr: fq.INSTRUCTION_IF};
  end

  assign fq.PC_write       = pc_write_q;
  assign fq.PC_ID          = head_pc;
  assign fq.INSTRUCTION_ID = head_instr;
  assign fq.valid_ID       = head_vld;
  assign fq.count          = cnt;
endmodule
